sc_stream_count: RTL

Stochastic-to-binary back-end for the 16-lane scaled unipolar MAC. It counts the ones in the MAC's single-bit output stream over a fixed window of 2^WIN_LOG2 cycles. The first LAT bits after `start` are discarded to cover the adder's register stage. The finished count is presented on a valid/ready output port. It sits directly downstream of the MAC's `oC` and feeds the binary accumulation/writeback logic.

---
 rtl/sc_cnt_pkg.sv | 15 +
 rtl/sc_stream_count_if.sv | 16 +
 rtl/sc_stream_count.sv | 113 +++++++++++
 3 files changed

// File: rtl/sc_cnt_pkg.sv
// Shared types and default sizing for the stochastic-to-binary counter.
package sc_cnt_pkg;

  // Defaults shared with the MAC wrapper so window and Sobol periods stay aligned.
  localparam int unsigned WIN_LOG2_DEF = 8;
  localparam int unsigned LAT_DEF      = 1;

  typedef enum logic [1:0] {
    IDLE,
    SKIP,
    RUN,
    DONE
  } sc_cnt_state_t;

endpackage

// File: rtl/sc_stream_count_if.sv
// Result port: registered count with a valid/ready handshake.
interface sc_stream_count_if
  import sc_cnt_pkg::*;
#(
  parameter int unsigned WIN_LOG2 = WIN_LOG2_DEF
) ();

  logic                oValid;
  logic                oReady;
  logic [WIN_LOG2:0]   oCount;

  // master: the counter producing results; slave: the consumer.
  modport master (output oValid, output oCount, input oReady);
  modport slave  (input oValid, input oCount, output oReady);

endinterface

// File: rtl/sc_stream_count.sv
// Counts ones in a stochastic bit stream over a 2^WIN_LOG2-cycle window,
// after discarding LAT leading bits, and presents the raw count on a
// valid/ready port.
module sc_stream_count
  import sc_cnt_pkg::*;
#(
  parameter int unsigned WIN_LOG2 = WIN_LOG2_DEF,
  parameter int unsigned LAT      = LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              iBit,
  output logic              busy,
  sc_stream_count_if.master res_if
);

  localparam int unsigned CW = WIN_LOG2 + 1;
  // Only meaningful when LAT > 0; SKIP is unreachable otherwise.
  localparam logic [3:0]  SkipLast = 4'(LAT - 1);

  sc_cnt_state_t          state_q, state_d;
  logic [3:0]             skip_cnt_q;
  logic [WIN_LOG2-1:0]    win_cnt_q;
  logic [CW-1:0]          acc_q;
  logic [CW-1:0]          count_q;
  logic                   win_last;
  logic [CW-1:0]          acc_next;

  assign win_last = &win_cnt_q;
  assign acc_next = acc_q + CW'(iBit);

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only looked at in IDLE, so it is never queued.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (LAT > 0) ? SKIP : RUN;
        end
      end
      SKIP: begin
        if (skip_cnt_q == SkipLast) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (win_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_if.oReady) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode directly from registered state, so no input reaches an output.
  always_comb begin
    busy          = (state_q != IDLE);
    res_if.oValid = (state_q == DONE);
    res_if.oCount = count_q;
  end

  // Skip/window counters, accumulator and result register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      skip_cnt_q <= '0;
      win_cnt_q  <= '0;
      acc_q      <= '0;
      count_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            skip_cnt_q <= '0;
            win_cnt_q  <= '0;
            acc_q      <= '0;
          end
        end
        SKIP: begin
          skip_cnt_q <= skip_cnt_q + 4'd1;
        end
        RUN: begin
          acc_q     <= acc_next;
          // Wraps to zero after the terminal all-ones count.
          win_cnt_q <= win_cnt_q + WIN_LOG2'(1);
          if (win_last) begin
            count_q <= acc_next;
          end
        end
        DONE: begin
          // Result held until the handshake; count_q keeps its value in IDLE.
        end
        default: begin
        end
      endcase
    end
  end

endmodule
